// File: rtl/seg_alloc_manager_pkg.sv
// Shared constants, queue entry type and FSM state encoding for the
// packet-buffer cell allocator.
package seg_alloc_pkg;

  localparam int NUM_PORTS = 16;
  localparam int NUM_PRIO  = 8;
  localparam int QDEPTH    = 16;
  localparam int ADDR_W    = 12;
  localparam int CELL_W    = 3;
  localparam int LEN_W     = 6;

  localparam int CELL_ID_W = ADDR_W - CELL_W;
  localparam int NCELLS    = 1 << CELL_ID_W;
  localparam int FREE_W    = CELL_ID_W + 1;
  localparam int PORT_W    = $clog2(NUM_PORTS);
  localparam int PRIO_W    = $clog2(NUM_PRIO);
  localparam int QPTR_W    = $clog2(QDEPTH);
  localparam int NQ        = NUM_PORTS * NUM_PRIO;
  localparam int QIDX_W    = PORT_W + PRIO_W;

  typedef struct packed {
    logic [CELL_ID_W-1:0] base;
    logic [LEN_W-1:0]     len;
  } q_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_FILL,
    ST_FREE
  } state_t;

  function automatic logic [QIDX_W-1:0] qidx(input logic [PORT_W-1:0] port,
                                             input logic [PRIO_W-1:0] prio);
    return {port, prio};
  endfunction

endpackage

// File: rtl/seg_alloc_manager_if.sv
// Request/response bundle between the ingress parser / SRAM controllers
// (master) and the allocator (slave).
interface seg_alloc_manager_if;
  import seg_alloc_pkg::*;

  // A request is accepted on a clock edge where valid && ready; the requester
  // holds its fields stable while valid is high. Responses are single-cycle
  // pulses with no backpressure.
  logic                 wr_req_valid;
  logic                 wr_req_ready;
  logic [LEN_W-1:0]     wr_len;
  logic [PORT_W-1:0]    wr_port;
  logic [PRIO_W-1:0]    wr_prio;
  logic                 wr_resp_valid;
  logic                 wr_resp_ok;
  logic [ADDR_W-1:0]    wr_resp_addr;
  logic                 rd_req_valid;
  logic                 rd_req_ready;
  logic [PORT_W-1:0]    rd_port;
  logic                 rd_resp_valid;
  logic                 rd_resp_ok;
  logic [ADDR_W-1:0]    rd_resp_addr;
  logic [LEN_W-1:0]     rd_resp_len;
  logic [PRIO_W-1:0]    rd_resp_prio;
  logic [FREE_W-1:0]    free_cells;
  state_t               dbg_state;

  modport slave (
    input  wr_req_valid, wr_len, wr_port, wr_prio, rd_req_valid, rd_port,
    output wr_req_ready, wr_resp_valid, wr_resp_ok, wr_resp_addr,
           rd_req_ready, rd_resp_valid, rd_resp_ok, rd_resp_addr,
           rd_resp_len, rd_resp_prio, free_cells, dbg_state
  );

  modport master (
    output wr_req_valid, wr_len, wr_port, wr_prio, rd_req_valid, rd_port,
    input  wr_req_ready, wr_resp_valid, wr_resp_ok, wr_resp_addr,
           rd_req_ready, rd_resp_valid, rd_resp_ok, rd_resp_addr,
           rd_resp_len, rd_resp_prio, free_cells, dbg_state
  );

endinterface

// File: rtl/seg_alloc_manager_queue_bank.sv
// Per-(port, prio) circular FIFOs of allocated segments, with a
// lowest-priority-index-first selector for the port being served.
module seg_queue_bank
  import seg_alloc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [PORT_W-1:0] push_port_i,
  input  logic [PRIO_W-1:0] push_prio_i,
  input  q_entry_t          push_entry_i,
  input  logic              pop_i,
  input  logic [PORT_W-1:0] pop_port_i,
  output logic              pop_valid_o,
  output logic [PRIO_W-1:0] pop_prio_o,
  output q_entry_t          pop_entry_o,
  output logic [NQ-1:0]     full_o
);

  localparam logic [QPTR_W:0] QFULL = (QPTR_W+1)'(QDEPTH);

  logic [QPTR_W-1:0] head_q  [NQ];
  logic [QPTR_W-1:0] tail_q  [NQ];
  logic [QPTR_W:0]   count_q [NQ];
  q_entry_t          mem_q   [NQ][QDEPTH];

  logic [QIDX_W-1:0] push_idx;
  logic [QIDX_W-1:0] pop_idx;
  logic              pop_fire;
  logic              same_q;

  assign push_idx = qidx(push_port_i, push_prio_i);

  // Descending scan so the lowest non-empty priority index wins.
  always_comb begin
    pop_valid_o = 1'b0;
    pop_prio_o  = '0;
    for (int p = NUM_PRIO - 1; p >= 0; p--) begin
      if (count_q[qidx(pop_port_i, PRIO_W'(p))] != '0) begin
        pop_valid_o = 1'b1;
        pop_prio_o  = PRIO_W'(p);
      end
    end
  end

  assign pop_idx     = qidx(pop_port_i, pop_prio_o);
  assign pop_entry_o = mem_q[pop_idx][head_q[pop_idx]];
  assign pop_fire    = pop_i && pop_valid_o;
  assign same_q      = push_i && pop_fire && (push_idx == pop_idx);

  for (genvar q = 0; q < NQ; q++) begin : g_full
    assign full_o[q] = (count_q[q] == QFULL);
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[push_idx][tail_q[push_idx]] <= push_entry_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int q = 0; q < NQ; q++) begin
        head_q[q]  <= '0;
        tail_q[q]  <= '0;
        count_q[q] <= '0;
      end
    end else begin
      if (push_i) tail_q[push_idx] <= tail_q[push_idx] + 1'b1;
      if (pop_fire) head_q[pop_idx] <= head_q[pop_idx] + 1'b1;
      if (push_i && !same_q) count_q[push_idx] <= count_q[push_idx] + 1'b1;
      if (pop_fire && !same_q) count_q[pop_idx] <= count_q[pop_idx] - 1'b1;
    end
  end

endmodule

// File: rtl/seg_alloc_manager.sv
// First-fit cell allocator over a free bitmap; allocation scans and
// fills/frees one cell per cycle, segments are queued per (port, prio).
module seg_alloc_manager
  import seg_alloc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  seg_alloc_manager_if.slave  bus
);

  localparam logic [CELL_ID_W-1:0] LAST_CELL = CELL_ID_W'(NCELLS - 1);

  state_t                state_q, state_d;
  logic [NCELLS-1:0]     used_q, used_d;
  logic [FREE_W-1:0]     free_q, free_d;
  logic [CELL_ID_W-1:0]  ptr_q, ptr_d, base_q, base_d;
  logic [LEN_W:0]        run_q, run_d, run_next;
  logic [LEN_W-1:0]      rem_q, rem_d, len_q, len_d;
  logic [PORT_W-1:0]     port_q, port_d;
  logic [PRIO_W-1:0]     prio_q, prio_d;
  logic                  wr_v_q, wr_v_d, wr_ok_q, wr_ok_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic                  rd_v_q, rd_v_d, rd_ok_q, rd_ok_d;
  logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
  logic [LEN_W-1:0]      rd_len_q, rd_len_d;
  logic [PRIO_W-1:0]     rd_prio_q, rd_prio_d;

  logic                  q_push, q_pop, q_nonempty;
  logic [PRIO_W-1:0]     q_prio;
  q_entry_t              q_head, push_entry;
  logic [NQ-1:0]         q_full;
  logic                  wr_reject;

  assign push_entry = '{base: base_q, len: len_q};

  seg_queue_bank u_qbank (
    .clk          (clk),
    .rst          (rst),
    .push_i       (q_push),
    .push_port_i  (port_q),
    .push_prio_i  (prio_q),
    .push_entry_i (push_entry),
    .pop_i        (q_pop),
    .pop_port_i   (bus.rd_port),
    .pop_valid_o  (q_nonempty),
    .pop_prio_o   (q_prio),
    .pop_entry_o  (q_head),
    .full_o       (q_full)
  );

  assign wr_reject = (bus.wr_len == '0) || (FREE_W'(bus.wr_len) > free_q) ||
                     q_full[qidx(bus.wr_port, bus.wr_prio)];
  assign run_next  = used_q[ptr_q] ? '0 : run_q + 1'b1;

  always_comb begin
    state_d = state_q;  used_d = used_q;  free_d = free_q;
    ptr_d   = ptr_q;    run_d  = run_q;   rem_d  = rem_q;
    base_d  = base_q;   len_d  = len_q;   port_d = port_q;  prio_d = prio_q;
    wr_v_d  = 1'b0;     wr_ok_d = 1'b0;   wr_addr_d = '0;
    rd_v_d  = 1'b0;     rd_ok_d = 1'b0;   rd_addr_d = '0;
    rd_len_d = '0;      rd_prio_d = '0;
    q_push  = 1'b0;     q_pop  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.rd_req_valid) begin
          q_pop  = 1'b1;
          rd_v_d = 1'b1;
          if (q_nonempty) begin
            rd_ok_d   = 1'b1;
            rd_addr_d = {q_head.base, {CELL_W{1'b0}}};
            rd_len_d  = q_head.len;
            rd_prio_d = q_prio;
            ptr_d     = q_head.base;
            rem_d     = q_head.len;
            state_d   = ST_FREE;
          end
        end else if (bus.wr_req_valid) begin
          if (wr_reject) begin
            wr_v_d = 1'b1;
          end else begin
            len_d   = bus.wr_len;
            port_d  = bus.wr_port;
            prio_d  = bus.wr_prio;
            ptr_d   = '0;
            run_d   = '0;
            state_d = ST_SCAN;
          end
        end
      end
      ST_SCAN: begin
        if (run_next == {1'b0, len_q}) begin
          base_d  = ptr_q - CELL_ID_W'(len_q) + CELL_ID_W'(1);
          ptr_d   = ptr_q - CELL_ID_W'(len_q) + CELL_ID_W'(1);
          rem_d   = len_q;
          state_d = ST_FILL;
        end else if (ptr_q == LAST_CELL) begin
          wr_v_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          ptr_d = ptr_q + 1'b1;
          run_d = run_next;
        end
      end
      ST_FILL: begin
        used_d[ptr_q] = 1'b1;
        free_d = free_q - 1'b1;
        ptr_d  = ptr_q + 1'b1;
        rem_d  = rem_q - 1'b1;
        if (rem_q == LEN_W'(1)) begin
          q_push    = 1'b1;
          wr_v_d    = 1'b1;
          wr_ok_d   = 1'b1;
          wr_addr_d = {base_q, {CELL_W{1'b0}}};
          state_d   = ST_IDLE;
        end
      end
      ST_FREE: begin
        used_d[ptr_q] = 1'b0;
        free_d = free_q + 1'b1;
        ptr_d  = ptr_q + 1'b1;
        rem_d  = rem_q - 1'b1;
        if (rem_q == LEN_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;  used_q <= '0;  free_q <= FREE_W'(NCELLS);
      ptr_q <= '0;  run_q <= '0;  rem_q <= '0;  base_q <= '0;
      len_q <= '0;  port_q <= '0;  prio_q <= '0;
      wr_v_q <= 1'b0;  wr_ok_q <= 1'b0;  wr_addr_q <= '0;
      rd_v_q <= 1'b0;  rd_ok_q <= 1'b0;  rd_addr_q <= '0;
      rd_len_q <= '0;  rd_prio_q <= '0;
    end else begin
      state_q <= state_d;  used_q <= used_d;  free_q <= free_d;
      ptr_q <= ptr_d;  run_q <= run_d;  rem_q <= rem_d;  base_q <= base_d;
      len_q <= len_d;  port_q <= port_d;  prio_q <= prio_d;
      wr_v_q <= wr_v_d;  wr_ok_q <= wr_ok_d;  wr_addr_q <= wr_addr_d;
      rd_v_q <= rd_v_d;  rd_ok_q <= rd_ok_d;  rd_addr_q <= rd_addr_d;
      rd_len_q <= rd_len_d;  rd_prio_q <= rd_prio_d;
    end
  end

  assign bus.wr_req_ready  = (state_q == ST_IDLE) && !bus.rd_req_valid;
  assign bus.rd_req_ready  = (state_q == ST_IDLE);
  assign bus.wr_resp_valid = wr_v_q;
  assign bus.wr_resp_ok    = wr_ok_q;
  assign bus.wr_resp_addr  = wr_addr_q;
  assign bus.rd_resp_valid = rd_v_q;
  assign bus.rd_resp_ok    = rd_ok_q;
  assign bus.rd_resp_addr  = rd_addr_q;
  assign bus.rd_resp_len   = rd_len_q;
  assign bus.rd_resp_prio  = rd_prio_q;
  assign bus.free_cells    = free_q;
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_seg_alloc_manager.sv
// Scoreboard bench for seg_alloc_manager: expected responses are queued when
// a request is driven and compared when the matching response pulse appears.
module tb_seg_alloc_manager;
  import seg_alloc_pkg::*;

  localparam int BUDGET = 2000;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] wr_exp_q[$];
  logic [31:0] rd_exp_q[$];

  seg_alloc_manager_if bus();

  seg_alloc_manager dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: compare every response pulse against the oldest expectation
  always @(negedge clk) begin
    if (bus.wr_resp_valid) begin
      if (wr_exp_q.size() == 0) chk("wr_unexpected", 32'(bus.wr_resp_valid), 32'd0);
      else chk("wr_resp", 32'({bus.wr_resp_ok, bus.wr_resp_addr}), wr_exp_q.pop_front());
    end
    if (bus.rd_resp_valid) begin
      if (rd_exp_q.size() == 0) chk("rd_unexpected", 32'(bus.rd_resp_valid), 32'd0);
      else chk("rd_resp", 32'({bus.rd_resp_ok, bus.rd_resp_addr, bus.rd_resp_len,
                               bus.rd_resp_prio}), rd_exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!bus.rd_req_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) chk("idle_timeout", 32'(bus.rd_req_ready), 32'd1);
  endtask

  task automatic do_write(input logic [LEN_W-1:0] len, input logic [PORT_W-1:0] port,
                          input logic [PRIO_W-1:0] prio, input logic ok,
                          input logic [ADDR_W-1:0] addr, output int lat);
    wait_idle();
    wr_exp_q.push_back(32'({ok, addr}));
    bus.wr_req_valid = 1'b1;
    bus.wr_len  = len;
    bus.wr_port = port;
    bus.wr_prio = prio;
    @(posedge clk);
    #1 bus.wr_req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.wr_resp_valid && lat < BUDGET);
    if (!bus.wr_resp_valid) chk("wr_timeout", 32'(bus.wr_resp_valid), 32'd1);
  endtask

  task automatic do_read(input logic [PORT_W-1:0] port, input logic ok,
                         input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                         input logic [PRIO_W-1:0] prio, output int lat);
    wait_idle();
    rd_exp_q.push_back(32'({ok, addr, len, prio}));
    bus.rd_req_valid = 1'b1;
    bus.rd_port = port;
    @(posedge clk);
    #1 bus.rd_req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rd_resp_valid && lat < BUDGET);
    if (!bus.rd_resp_valid) chk("rd_timeout", 32'(bus.rd_resp_valid), 32'd1);
  endtask

  task automatic chk_free(input string tag, input int exp);
    wait_idle();
    chk(tag, 32'(bus.free_cells), 32'(exp));
  endtask

  initial begin
    int lat;
    int sum;
    logic [LEN_W-1:0]  rl;
    logic [PRIO_W-1:0] rp;

    bus.wr_req_valid = 1'b0;
    bus.wr_len = '0;
    bus.wr_port = '0;
    bus.wr_prio = '0;
    bus.rd_req_valid = 1'b0;
    bus.rd_port = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_wr_valid", 32'(bus.wr_resp_valid), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_resp_valid), 32'd0);
    chk("rst_wr_addr", 32'(bus.wr_resp_addr), 32'd0);
    chk("rst_rd_addr", 32'(bus.rd_resp_addr), 32'd0);
    chk("rst_free", 32'(bus.free_cells), 32'd512);
    chk("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));

    // first allocation on empty memory
    do_write(6'd4, 4'd2, 3'd3, 1'b1, 12'h000, lat);
    chk("first_lat", 32'(lat), 32'd9);
    chk_free("first_free", 508);
    do_read(4'd2, 1'b1, 12'h000, 6'd4, 3'd3, lat);
    chk("rd_lat", 32'(lat), 32'd1);
    chk_free("first_freed", 512);

    // fragmentation: hole of 4 cells at cell 4
    do_write(6'd4, 4'd0, 3'd0, 1'b1, 12'h000, lat);
    do_write(6'd4, 4'd1, 3'd0, 1'b1, 12'h020, lat);
    do_write(6'd4, 4'd0, 3'd0, 1'b1, 12'h040, lat);
    do_read(4'd1, 1'b1, 12'h020, 6'd4, 3'd0, lat);
    do_write(6'd6, 4'd4, 3'd0, 1'b1, 12'h060, lat);
    do_write(6'd4, 4'd4, 3'd0, 1'b1, 12'h020, lat);
    chk_free("frag_free", 494);
    do_read(4'd0, 1'b1, 12'h000, 6'd4, 3'd0, lat);
    do_read(4'd0, 1'b1, 12'h040, 6'd4, 3'd0, lat);
    do_read(4'd4, 1'b1, 12'h060, 6'd6, 3'd0, lat);
    do_read(4'd4, 1'b1, 12'h020, 6'd4, 3'd0, lat);
    chk_free("frag_freed", 512);

    // priority order within a port
    do_write(6'd2, 4'd5, 3'd6, 1'b1, 12'h000, lat);
    do_write(6'd3, 4'd5, 3'd1, 1'b1, 12'h010, lat);
    do_read(4'd5, 1'b1, 12'h010, 6'd3, 3'd1, lat);
    do_read(4'd5, 1'b1, 12'h000, 6'd2, 3'd6, lat);
    do_read(4'd5, 1'b0, 12'h000, 6'd0, 3'd0, lat);
    chk_free("prio_freed", 512);

    // queue full
    for (int i = 0; i < 16; i++) do_write(6'd1, 4'd3, 3'd0, 1'b1, 12'(i << 3), lat);
    chk_free("qfull_free", 496);
    do_write(6'd1, 4'd3, 3'd0, 1'b0, 12'h000, lat);
    chk("qfull_lat", 32'(lat), 32'd1);
    chk_free("qfull_free_after", 496);
    for (int i = 0; i < 16; i++) do_read(4'd3, 1'b1, 12'(i << 3), 6'd1, 3'd0, lat);
    chk_free("qfull_freed", 512);

    // zero length reject
    do_write(6'd0, 4'd1, 3'd2, 1'b0, 12'h000, lat);
    chk("zero_lat", 32'(lat), 32'd1);

    // read and write together: read wins, write not accepted
    wait_idle();
    rd_exp_q.push_back(32'({1'b0, 12'h000, 6'd0, 3'd0}));
    bus.rd_req_valid = 1'b1;
    bus.rd_port = 4'd6;
    bus.wr_req_valid = 1'b1;
    bus.wr_len = 6'd2;
    bus.wr_port = 4'd1;
    bus.wr_prio = 3'd0;
    #1 chk("contend_wr_ready", 32'(bus.wr_req_ready), 32'd0);
    @(posedge clk);
    #1 begin
      bus.rd_req_valid = 1'b0;
      bus.wr_req_valid = 1'b0;
    end
    repeat (4) @(negedge clk);
    chk("contend_free", 32'(bus.free_cells), 32'd512);

    // reset in the middle of a fill: no response, all state cleared
    wait_idle();
    bus.wr_req_valid = 1'b1;
    bus.wr_len = 6'd8;
    bus.wr_port = 4'd9;
    bus.wr_prio = 3'd0;
    @(posedge clk);
    #1 bus.wr_req_valid = 1'b0;
    repeat (11) @(negedge clk);
    chk("mid_fill_state", 32'(bus.dbg_state), 32'(ST_FILL));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_fill_free", 32'(bus.free_cells), 32'd512);
    do_read(4'd9, 1'b0, 12'h000, 6'd0, 3'd0, lat);

    // random lengths packed back to back
    sum = 0;
    for (int i = 0; i < 6; i++) begin
      rl = 6'($urandom_range(1, 8));
      rp = 3'($urandom_range(0, 7));
      do_write(rl, 4'd7, rp, 1'b1, 12'(sum << 3), lat);
      chk("rand_lat", 32'(lat), 32'(sum + 2 * int'(rl) + 1));
      sum += int'(rl);
    end
    chk_free("rand_free", 512 - sum);

    repeat (3) @(negedge clk);
    chk("wr_exp_left", 32'(wr_exp_q.size()), 32'd0);
    chk("rd_exp_left", 32'(rd_exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
